if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
Instruction prefetch stage between the instruction memory and the IF/ID pipeline register. It issues sequential fetch requests, keeps several requests in flight, and buffers returned instructions with their PCs in a small FIFO. It presents one instruction per cycle to the IF/ID register under a valid/ready handshake. On a taken branch (PCSrc with target PC) it flushes all buffered and in-flight instructions and restarts fetching at the target.

Parameters:
DEPTH, 4, FIFO entries; also the cap on queued plus outstanding requests (power of two, >= 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word aligned (bits [1:0] = 00)
imem_ready  input  1  memory accepts request this cycle (request accepted when imem_req && imem_ready)
imem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after acceptance
imem_rdata  input  32  instruction word
redirect_valid  input  1  taken branch/flush (driven by PCSrc)
redirect_pc  input  32  branch target (PC_Branch from the MEM stage); bits [1:0] ignored
inst_valid  output  1  head of queue valid
inst_pc  output  32  PC of head instruction
inst_data  output  32  head instruction word
inst_ready  input  1  consumer accepts head (driven by IF_ID_write)
queue_count  output  clog2(DEPTH)+1  entries currently held, for debug

Behaviour:
- Reset (synchronous, active-high, dominates every other input): fetch_pc <= RESET_PC, FIFO empty, outstanding = 0, discard = 0. Outputs while and directly after reset: imem_req=0, inst_valid=0, inst_pc=0, inst_data=0, queue_count=0. Reset during outstanding requests drops them: a response arriving after reset with outstanding==0 is ignored.
- Issue: imem_req = !reset_state && !redirect_valid && (queue_count + outstanding < DEPTH). imem_addr = fetch_pc. On acceptance, fetch_pc += 4 (32-bit wrap from FFFF_FFFC to 0000_0000) and outstanding += 1.
- Response: on imem_rvalid, outstanding -= 1.
  - If discard > 0: drop the data and decrement discard.
  - Otherwise push {resp_pc, imem_rdata}. resp_pc is a separate counter advanced by 4 per accepted response.
  - The space reservation guarantees the FIFO never overflows. A push when full is an assertion failure.
- Pop: when inst_valid && inst_ready, the head is removed. inst_valid = (queue_count != 0). inst_pc and inst_data show the head entry, and show 0 when the queue is empty.
- Latency: request accepted in cycle N, rvalid in cycle N+1 at the earliest, inst_valid in cycle N+2. Steady-state throughput is 1 instruction/cycle with DEPTH >= 3 and a 1-cycle memory.
- Simultaneous push and pop: both occur and queue_count is unchanged. A push into an empty queue is not bypassed to the outputs in the same cycle.
- Redirect (redirect_valid=1 in cycle R):
  - FIFO cleared; any pop in cycle R is ignored.
  - imem_req=0 in cycle R.
  - discard <= outstanding - (imem_rvalid ? 1 : 0), counting only responses still in flight that are not already marked for discard. The rvalid in cycle R is itself dropped.
  - fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}.
  - In cycle R+1, imem_req may assert with imem_addr = the target.
  - Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Stall: with inst_ready=0 the queue fills, then issue stops when queue_count + outstanding == DEPTH. No instruction is lost or duplicated.
- imem_rvalid while outstanding==0: ignored (protocol error).
- Counters outstanding, discard, and queue_count have width clog2(DEPTH)+1 and never wrap.

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1: requests to 0x0, 0x4, 0x8 on consecutive cycles; first inst_valid 2 cycles after the first accept with inst_pc=0x0; then one instruction per cycle, PCs consecutive.
- Stall: inst_ready=0 for 10 cycles, DEPTH=4: queue_count saturates at 4, imem_req=0, outstanding=0. Release: PCs 0x0..0xC delivered in order, then fetch resumes at 0x10.
- Redirect with 2 in flight (3-cycle memory latency): redirect_pc=0x100 → FIFO empties that cycle; the next 2 responses are dropped; the next delivered instruction has inst_pc=0x100 with its data.
- Redirect coincident with rvalid and pop: redirect_pc=0x203 → the returning word is dropped, no pop occurs, and the next request addr is 0x200.
- imem_ready low for 5 cycles: imem_req and imem_addr stay stable, fetch_pc does not advance, no duplicate request is issued.
- Reset asserted with 3 outstanding: all outputs return to their reset values; subsequent stray rvalids are ignored; the first delivered instruction has inst_pc=RESET_PC.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue sitting between instruction memory and the IF/ID
// register. It issues sequential word fetches, keeps several in flight, buffers
// returned words with their PCs and hands them out one per cycle. A taken branch
// flushes everything buffered or in flight and restarts fetching at the target.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst_pc,
  output logic [31:0]              inst_data,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [CW:0]   reserved;
  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;

  // Buffered plus in-flight words may never exceed the FIFO size, so every
  // response has a slot waiting for it.
  assign reserved    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = !reset && !redirect_valid && (reserved < CAP);
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp        = imem_rvalid && (outstanding != '0);
  assign push        = resp && !redirect_valid && (discard == '0);

  // The redirect cycle throws the whole queue away, so a pop then is moot.
  assign inst_valid  = (count != '0);
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign inst_pc     = inst_valid ? pc_mem[rd_ptr]   : '0;
  assign inst_data   = inst_valid ? data_mem[rd_ptr] : '0;
  assign queue_count = count;

  // Control state: fetch/response PCs, occupancy, in-flight and discard counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= word_align(RESET_PC);
      resp_pc     <= word_align(RESET_PC);
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (redirect_valid) begin
        // Every request still in flight belongs to the old path; the one
        // returning right now is dropped directly and not counted again.
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        discard  <= outstanding - CW'(resp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage; contents are only visible through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr]   <= resp_pc;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

  // The space reservation makes a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && (count == CW'(DEPTH))));
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: an in-order memory model with a
// selectable latency answers requests; each step checks outputs against
// hand-derived cycle-by-cycle values.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic [2:0]  queue_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t q[$];

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is derived from its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample the handshake mid-cycle, advance, then let the memory
  // model present the next in-order response once its latency has elapsed.
  task automatic tick();
    logic        acc;
    logic        rv;
    logic [31:0] a;
    req_t        r;
    @(negedge clk);
    acc = imem_req && imem_ready;
    a   = imem_addr;
    rv  = imem_rvalid;
    @(posedge clk);
    #1;
    cyc++;
    if (rv && q.size() > 0) q.delete(0);
    if (acc) begin
      r.addr = a;
      r.due  = cyc - 1 + lat;
      q.push_back(r);
    end
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  // Hold reset until the memory model has nothing left to return.
  task automatic do_reset();
    int n;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    imem_ready     = 1'b1;
    tick();
    tick();
    n = 0;
    while (q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;

    // Reset values
    do_reset();
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_valid", 32'(inst_valid),  32'd0);
    chk("rst_pc",    inst_pc,          32'h0);
    chk("rst_data",  inst_data,        32'h0);
    chk("rst_count", 32'(queue_count), 32'd0);

    // Sequential fetch, 1-cycle memory, consumer always ready
    lat = 1; reset = 1'b0; #1;
    chk("seq_req0",  32'(imem_req), 32'd1);
    chk("seq_addr0", imem_addr,     32'h0);
    tick();
    chk("seq_addr1",  imem_addr,       32'h4);
    chk("seq_valid1", 32'(inst_valid), 32'd0);
    tick();
    chk("seq_valid2", 32'(inst_valid), 32'd1);
    chk("seq_pc2",    inst_pc,         32'h0);
    chk("seq_data2",  inst_data,       mem_word(32'h0));
    chk("seq_addr2",  imem_addr,       32'h8);
    tick();
    chk("seq_pc3",    inst_pc,          32'h4);
    chk("seq_data3",  inst_data,        mem_word(32'h4));
    chk("seq_count3", 32'(queue_count), 32'd1);
    tick();
    chk("seq_pc4",    inst_pc,          32'h8);

    // Stall: consumer blocked, queue fills and issue stops
    do_reset();
    lat = 1; inst_ready = 1'b0; reset = 1'b0; #1;
    repeat (10) tick();
    chk("stall_count", 32'(queue_count), 32'd4);
    chk("stall_req",   32'(imem_req),    32'd0);
    chk("stall_addr",  imem_addr,        32'h10);
    chk("stall_pc",    inst_pc,          32'h0);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_rel_valid", 32'(inst_valid), 32'd1);
      chk("stall_rel_pc",    inst_pc,         32'(i * 4));
      chk("stall_rel_data",  inst_data,       mem_word(32'(i * 4)));
      if (i == 1) begin
        chk("stall_resume_req",  32'(imem_req), 32'd1);
        chk("stall_resume_addr", imem_addr,     32'h10);
      end
      tick();
    end
    chk("stall_after_pc",   inst_pc,   32'h10);
    chk("stall_after_data", inst_data, mem_word(32'h10));

    // Redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3; inst_ready = 1'b0; imem_ready = 1'b1; reset = 1'b0; #1;
    chk("rd2_req0", 32'(imem_req), 32'd1);
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("rd2_pre_valid", 32'(inst_valid),  32'd1);
    chk("rd2_pre_pc",    inst_pc,          32'h0);
    chk("rd2_pre_count", 32'(queue_count), 32'd1);
    chk("rd2_pre_addr",  imem_addr,        32'h4);
    imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("rd2_req_in_redirect", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0; imem_ready = 1'b1; #1;
    chk("rd2_flush_valid", 32'(inst_valid),  32'd0);
    chk("rd2_flush_count", 32'(queue_count), 32'd0);
    chk("rd2_tgt_req",     32'(imem_req),    32'd1);
    chk("rd2_tgt_addr",    imem_addr,        32'h100);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd2_drop_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    chk("rd2_tgt_valid", 32'(inst_valid), 32'd1);
    chk("rd2_tgt_pc",    inst_pc,         32'h100);
    chk("rd2_tgt_data",  inst_data,       mem_word(32'h100));

    // Redirect coinciding with a response and a pop; unaligned target
    do_reset();
    lat = 1; inst_ready = 1'b1; imem_ready = 1'b1; reset = 1'b0; #1;
    tick();
    tick();
    chk("rdc_head_pc", inst_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
    chk("rdc_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("rdc_valid", 32'(inst_valid),  32'd0);
    chk("rdc_count", 32'(queue_count), 32'd0);
    chk("rdc_req1",  32'(imem_req),    32'd1);
    chk("rdc_addr1", imem_addr,        32'h200);
    tick();
    chk("rdc_valid2", 32'(inst_valid), 32'd0);
    tick();
    chk("rdc_valid3", 32'(inst_valid), 32'd1);
    chk("rdc_pc3",    inst_pc,         32'h200);
    chk("rdc_data3",  inst_data,       mem_word(32'h200));

    // Memory not ready: request held stable, no duplicates afterwards
    do_reset();
    lat = 1; imem_ready = 1'b0; inst_ready = 1'b1; reset = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("nrdy_req",   32'(imem_req),   32'd1);
      chk("nrdy_addr",  imem_addr,       32'h0);
      chk("nrdy_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    imem_ready = 1'b1;
    chk("nrdy_addr_acc", imem_addr, 32'h0);
    tick();
    chk("nrdy_addr_next", imem_addr, 32'h4);
    tick();
    chk("nrdy_pc0", inst_pc, 32'h0);
    tick();
    chk("nrdy_pc1", inst_pc, 32'h4);

    // Reset with three requests outstanding; stray responses ignored
    do_reset();
    lat = 3; inst_ready = 1'b1; imem_ready = 1'b1; reset = 1'b0; #1;
    tick();
    tick();
    tick();
    reset = 1'b1; #1;
    chk("rst3_req", 32'(imem_req), 32'd0);
    tick();
    reset = 1'b0; imem_ready = 1'b0; #1;
    chk("rst3_valid", 32'(inst_valid),  32'd0);
    chk("rst3_pc",    inst_pc,          32'h0);
    chk("rst3_data",  inst_data,        32'h0);
    chk("rst3_count", 32'(queue_count), 32'd0);
    tick();
    chk("rst3_stray_valid1", 32'(inst_valid),  32'd0);
    chk("rst3_stray_count1", 32'(queue_count), 32'd0);
    tick();
    chk("rst3_stray_valid2", 32'(inst_valid),  32'd0);
    chk("rst3_stray_count2", 32'(queue_count), 32'd0);
    imem_ready = 1'b1;
    n = 0;
    while (inst_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk("rst3_first_wait",  32'(inst_valid), 32'd1);
    chk("rst3_first_delay", 32'(n),          32'd4);
    chk("rst3_first_pc",    inst_pc,         32'h0);
    chk("rst3_first_data",  inst_data,       mem_word(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
